// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default framing constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int OVERSAMPLE      = 16;
  localparam int DBIT_DEFAULT    = 8;
  localparam int SB_TICK_DEFAULT = 16;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side signal bundle: baud strobe and serial line in, word and status out.
interface uart_rx_if
  import uart_pkg::*;
#(
  parameter int DBIT = DBIT_DEFAULT
);
  logic            s_tick;
  logic            rx;
  logic [DBIT-1:0] dout;
  logic            rx_done_tick;
  logic            frame_err;
  logic            busy;

  modport master (output s_tick, rx, input dout, rx_done_tick, frame_err, busy);
  modport slave  (input s_tick, rx, output dout, rx_done_tick, frame_err, busy);
endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/uart_rx.sv
// 16x oversampling UART receiver.
// state | meaning: IDLE wait for low line | START check mid start bit | DATA sample bits | STOP sample stop bit
module uart_rx
  import uart_pkg::*;
#(
  parameter int DBIT    = DBIT_DEFAULT,
  parameter int SB_TICK = SB_TICK_DEFAULT
) (
  input logic       clk,
  input logic       reset,
  uart_rx_if.slave  bus
);
  // Tick counter grows past 4 bits only when the stop bit needs it.
  localparam int SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : 4;

  uart_state_t     state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [2:0]      n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            ferr_q, ferr_d;
  logic            rx_s;

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (bus.rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          s_d     = '0;
        end
      end
      START: begin
        if (bus.s_tick) begin
          if (s_q == SW'(7)) begin
            // A start bit that is high again at its midpoint was a glitch.
            if (!rx_s) begin
              state_d = DATA;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      DATA: begin
        if (bus.s_tick) begin
          if (s_q == SW'(15)) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == 3'(DBIT - 1)) state_d = STOP;
            else                     n_d = n_q + 3'd1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      STOP: begin
        if (bus.s_tick) begin
          if (s_q == SW'(SB_TICK - 1)) begin
            state_d = IDLE;
            if (rx_s) begin
              dout_d = b_q;
              done_d = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.dout         = dout_q;
  assign bus.rx_done_tick = done_q;
  assign bus.frame_err    = ferr_q;
  assign bus.busy         = (state_q != IDLE);
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter DBIT, default 8, number of data bits per frame (5..8).
REQ-002 SHALL have parameter SB_TICK, default 16, stop-bit length in s_tick units (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 SHALL have port clk, input, 1, system clock; all state changes on posedge clk.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port s_tick, input, 1, one-clk sampling strobe at 16x the baud rate, from the baud generator.
REQ-006 SHALL have port rx, input, 1, asynchronous serial line; idles high.
REQ-007 SHALL have port dout, output, DBIT, last received data word, LSB first on the line.
REQ-008 SHALL have port rx_done_tick, output, 1, one-clk pulse when a valid frame completes.
REQ-009 SHALL have port frame_err, output, 1, one-clk pulse when the stop bit samples low.
REQ-010 SHALL have port busy, output, 1, high whenever the state is not IDLE.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer (reset value 1); the FSM SHALL use only the synchronized value rx_s.
REQ-012 The FSM SHALL have four states: IDLE, START, DATA, STOP. It SHALL also keep a 4-bit tick counter s, a 3-bit bit counter n, and a DBIT-wide shift register b.
REQ-013 s SHALL change only in cycles where s_tick=1, except for explicit clears on state entry.
REQ-014 IDLE: when rx_s=0 (s_tick not required), the FSM SHALL go to START and clear s to 0.
REQ-015 START: on the s_tick where s==7 (mid start bit), if rx_s=0 the FSM SHALL go to DATA with s=0, n=0. If rx_s=1 it SHALL return to IDLE as glitch rejection, with no output pulse.
REQ-016 DATA: on the s_tick where s==15, the FSM SHALL shift rx_s into the MSB of b (right shift) and clear s. If n==DBIT-1 it SHALL go to STOP; otherwise n SHALL increment.
REQ-017 STOP: on the s_tick where s==SB_TICK-1, the FSM SHALL sample rx_s and go to IDLE.
  - rx_s=1: load dout<=b and pulse rx_done_tick for one clk.
  - rx_s=0: pulse frame_err for one clk; dout unchanged.
REQ-018 For SB_TICK>16 the stop count SHALL use a counter wide enough for SB_TICK-1, so no wrap occurs before the terminal count.
REQ-019 rx_done_tick and frame_err SHALL be registered, mutually exclusive, and asserted in the cycle after the terminal s_tick.
REQ-020 A falling edge on rx during DATA or STOP SHALL NOT restart the frame; bits SHALL be taken only at the scheduled sample points.
REQ-021 A back-to-back frame SHALL be accepted: the start bit may be detected on the cycle after the return to IDLE.
REQ-022 s_tick held high continuously SHALL be legal: every clk then counts as one tick.
REQ-023 dout SHALL hold its value until the next valid frame completes.

Reset
REQ-024 While reset is high: state=IDLE, s=0, n=0, b=0, dout=0, rx_done_tick=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no output pulse. After release the FSM SHALL wait in IDLE for the next rx_s=0.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum (IDLE/START/DATA/STOP) and the constants OVERSAMPLE=16, DBIT_DEFAULT=8, SB_TICK_DEFAULT=16, shared with the future uart_tx.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff (1-bit, parameterized reset value). The rest SHALL be implemented in uart_rx.

Verification
REQ-028 s_tick every 4 clk, send 0xA5 8N1 (line bits 0,1,0,1,0,0,1,0,1,1) -> one rx_done_tick, dout=0xA5, frame_err never high, busy low after the pulse.
REQ-029 rx low for only 5 ticks, then high -> FSM returns to IDLE, no rx_done_tick, no frame_err, dout unchanged.
REQ-030 Send 0x3C with the stop bit forced low -> one frame_err pulse, no rx_done_tick, dout keeps its previous value (0xA5).
REQ-031 Send two back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done_tick pulses with dout=0x00 then 0xFF.
REQ-032 Assert reset during bit 4 of a frame -> all outputs 0 immediately, no pulse. The next clean frame 0x5A -> dout=0x5A.
REQ-033 DBIT=7, SB_TICK=32, send 0x41 -> rx_done_tick fires only after 32 stop ticks, dout=7'h41.
